// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - multi-channel fractional clock-enable generator with PLL lock/reset sequencer
module clk_en_gen #(
    parameter  int NUM_CH    = 4,
    parameter  int ACC_W     = 16,
    parameter  int LOCK_WAIT = 1024,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pll_lock,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              resync,
    output logic [NUM_CH-1:0] ce,
    output logic              rst_out_n,
    output logic              running
);

    localparam int CNT_W = $clog2(LOCK_WAIT + 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_rst_out_n;
    logic               r_running;
    logic               w_accum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_RESET;
            r_cnt       <= '0;
            r_rst_out_n <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_rst_out_n <= (w_state_nx == S_RUN);
            r_running   <= (w_state_nx == S_RUN);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_RESET: w_state_nx = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (r_sync2) begin
                    w_state_nx = S_SETTLE;
                    w_cnt_nx   = '0;
                end
            end
            S_SETTLE: begin
                if (!r_sync2) begin
                    w_state_nx = S_WAIT_LOCK;
                end else if (r_cnt == CNT_W'(LOCK_WAIT - 1)) begin
                    w_state_nx = S_RUN;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!r_sync2) begin
                    w_state_nx = S_WAIT_LOCK;
                end
            end
            default: w_state_nx = S_RESET;
        endcase
    end

    // Accumulate only when staying in RUN, so the exit edge already forces ce low and reloads phase
    assign w_accum = (r_state == S_RUN) && (w_state_nx == S_RUN) && !resync;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_W-1:0] r_inc;
        logic [ACC_W-1:0] r_phase;
        logic [ACC_W-1:0] r_acc;
        logic             r_ce;
        logic             w_wr;
        logic [ACC_W:0]   w_sum;
        logic [ACC_W-1:0] w_phase_nx;

        assign w_wr       = cfg_we && (cfg_ch == CH_W'(g));
        assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc};
        assign w_phase_nx = w_wr ? cfg_phase : r_phase;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_inc   <= '0;
                r_phase <= '0;
                r_acc   <= '0;
                r_ce    <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_inc   <= cfg_inc;
                    r_phase <= cfg_phase;
                end
                if (w_accum) begin
                    r_acc <= w_sum[ACC_W-1:0];
                    r_ce  <= w_sum[ACC_W];
                end else begin
                    r_acc <= w_phase_nx;
                    r_ce  <= 1'b0;
                end
            end
        end

        assign ce[g] = r_ce;
    end

    assign rst_out_n = r_rst_out_n;
    assign running   = r_running;

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Parametrised multi-channel clock-enable generator and lock/reset sequencer for the fabric clock domain. It sits directly behind the board PLL: it takes one PLL output clock plus the PLL lock flag. It produces NUM_CH fractional-rate clock-enable pulses with programmable ratio and phase, and a sequenced active-low reset for downstream logic. Use it where a design needs more derived rates than the PLL has outputs, or needs rate and phase changed at runtime without re-locking the PLL.

## Interface
- NUM_CH, 4: number of clock-enable channels (1..16).
- ACC_W, 16: phase-accumulator width in bits. Output rate = f_clk * inc / 2^ACC_W.
- LOCK_WAIT, 1024: number of clk cycles the synchronised lock must stay high before RUN (minimum 1).
- clk  in  1  fabric clock (PLL output).
- resetn  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL lock, asynchronous to clk.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index for the write. Indices >= NUM_CH are ignored.
- cfg_inc  in  ACC_W  per-channel increment.
- cfg_phase  in  ACC_W  per-channel phase (accumulator reload value).
- resync  in  1  reload all accumulators with their phase values.
- ce  out  NUM_CH  one-cycle clock-enable pulses, registered.
- rst_out_n  out  1  downstream reset, active low, registered.
- running  out  1  high while in RUN.

## Operation
- pll_lock passes through a 2-flop synchroniser to give lock_s. The synchroniser flops reset to 0.
- State machine:
  - RESET: entered on resetn low. Leaves to WAIT_LOCK on the first clk edge after resetn deasserts.
  - WAIT_LOCK: moves to SETTLE when lock_s = 1. The settle counter loads 0.
  - SETTLE: the counter increments each cycle. If lock_s = 0, go to WAIT_LOCK. When the counter reaches LOCK_WAIT-1 with lock_s = 1, go to RUN.
  - RUN: if lock_s = 0, go to WAIT_LOCK.
- rst_out_n = 1 and running = 1 only in RUN. Both are registered from the next-state value, so they rise on the edge that enters RUN.
- Per channel, the block holds inc[i], phase[i] and acc[i]. All reset to 0.
- cfg_we with a valid cfg_ch writes inc and phase for that channel in any state. It does not touch acc.
- Outside RUN:
  - acc[i] is continuously loaded with phase[i], using the newly written value if a write happens in the same cycle.
  - ce is forced to 0.
- In RUN:
  - {carry, acc[i]} = acc[i] + inc[i], computed at ACC_W+1 bits with wrap-around modulo 2^ACC_W.
  - ce[i] is registered from carry.
  - inc = 0 means the channel never fires.
- resync in RUN: every acc[i] loads phase[i] and ce is 0 for that cycle.
  - If cfg_we and resync occur in the same cycle, the written channel reloads with the new phase.
  - resync outside RUN has no additional effect.
- Losing lock mid-operation: ce goes to 0, rst_out_n goes to 0 and accumulators reload from phase. Re-entry to RUN always starts phase-aligned.
- Asserting resetn mid-operation clears everything immediately, including the config registers.

## Timing
- Reset values: ce = 0, rst_out_n = 0, running = 0, state RESET, all inc/phase/acc = 0, settle counter 0.
- Lock-rise to RUN: pll_lock rise, then 2 cycles of sync, then 1 cycle to enter SETTLE, then LOCK_WAIT cycles in SETTLE, then RUN.
- Lock-fall to reset: pll_lock fall reaches rst_out_n = 0 and ce = 0 within 3 clk edges (2 sync plus 1 state register).
- First ce: channel i first pulses on cycle k after RUN entry, counting the RUN-entry edge as k = 0, where k is the smallest value with phase[i] + k*inc[i] >= 2^ACC_W.
- Config write in RUN: the new inc is used in the accumulation on the following edge. The accumulator value is not altered.
- resync: the first accumulation from the phase value happens on the edge after the reload edge.
- Maximum rate: inc = 2^ACC_W - 1 gives ce high on all but one cycle in every 2^ACC_W cycles.

## Test plan
- ACC_W=16, LOCK_WAIT=8. Write ch0 with inc=0x4000, phase=0. Raise pll_lock -> rst_out_n rises 11 edges after the lock edge; ce[0] pulses on RUN cycles 4, 8, 12, …
- ch1 inc=0x4000, phase=0x8000, alongside ch0 -> ce[1] on RUN cycles 2, 6, 10, i.e. 2 cycles ahead of ce[0]. A resync restores this 2-cycle offset after ch0 has been retuned to inc=0x2000.
- Fractional rate: inc=0x5555 -> exactly 1 pulse per 3 cycles (±1-cycle jitter) over 3000 cycles, 1000 pulses ±1.
- pll_lock glitch low for 1 cycle during SETTLE -> state returns to WAIT_LOCK and the settle count restarts. rst_out_n stays 0.
- pll_lock drop in RUN -> ce = 0 and rst_out_n = 0 within 3 edges. Relock -> after settle, the pulse pattern restarts identically from phase.
- resetn asserted mid-RUN with cfg_we active -> all outputs 0 immediately and config cleared. After release, no ce pulses occur until reprogrammed.
